// File: rtl/seg_scan_reader.sv
// Readback decoder for the multiplexed 7-segment bus: settles each anode strobe, decodes BCD, publishes full frames.
// Optional error detection is enabled with `define SEG_READER_ERR_EN (otherwise err is tied low).
module seg_scan_reader #(
    parameter int DIGITS = 4,
    parameter int SETTLE = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DIGITS-1:0]     an,
    input  logic [6:0]            seg,
    input  logic                  err_clr,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  frame_valid,
    output logic                  err
);
    localparam int CW = $clog2(SETTLE + 1);

    logic [DIGITS-1:0]   an_s1_reg, an_s_reg;
    logic [6:0]          seg_s1_reg, seg_s_reg;
    logic [DIGITS-1:0]   a_act;
    logic [6:0]          p;
    logic [DIGITS-1:0]   cur_reg;
    logic [CW-1:0]       cnt_reg;
    logic                stable, onehot, multi_hot, strobe;
    logic [3:0]          dec_val;
    logic                dec_ok;
    logic                pattern_err, conflict_err;
    logic [4*DIGITS-1:0] shadow_reg, shadow_next;
    logic [DIGITS-1:0]   mask_reg, mask_next, hit;
    logic                full;

    // Both buses share one synchronizer depth so a segment pattern stays aligned with its anode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an_s1_reg  <= '1;
            an_s_reg   <= '1;
            seg_s1_reg <= '1;
            seg_s_reg  <= '1;
        end else begin
            an_s1_reg  <= an;
            an_s_reg   <= an_s1_reg;
            seg_s1_reg <= seg;
            seg_s_reg  <= seg_s1_reg;
        end
    end

    assign a_act     = ~an_s_reg;
    assign p         = ~seg_s_reg;
    assign stable    = (a_act == cur_reg);
    assign onehot    = $onehot(a_act);
    assign multi_hot = (a_act != '0) && !onehot;
    // Fires on the cycle the counter reaches SETTLE, so each activation samples at most once.
    assign strobe    = stable && onehot && (cnt_reg == CW'(SETTLE - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_reg <= '0;
            cnt_reg <= '0;
        end else if (!stable) begin
            cur_reg <= a_act;
            cnt_reg <= '0;
        end else if (onehot && (cnt_reg < CW'(SETTLE))) begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    always_comb begin
        dec_val = 4'hF;
        dec_ok  = 1'b1;
        case (p)
            7'h3F:   dec_val = 4'd0;
            7'h06:   dec_val = 4'd1;
            7'h5B:   dec_val = 4'd2;
            7'h4F:   dec_val = 4'd3;
            7'h66:   dec_val = 4'd4;
            7'h6D:   dec_val = 4'd5;
            7'h7D:   dec_val = 4'd6;
            7'h07:   dec_val = 4'd7;
            7'h7F:   dec_val = 4'd8;
            7'h6F:   dec_val = 4'd9;
            7'h00:   dec_val = 4'hF;
            default: dec_ok  = 1'b0;
        endcase
    end

    assign pattern_err  = strobe && !dec_ok;
    assign conflict_err = multi_hot;
    assign full         = &mask_reg;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign hit[gi] = strobe && dec_ok && a_act[gi];
            assign shadow_next[4*gi +: 4] = hit[gi] ? dec_val : shadow_reg[4*gi +: 4];
        end
    endgenerate

    // A capture landing on the publish edge survives the clear and starts the next frame.
    assign mask_next = (full ? '0 : mask_reg) | hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_reg  <= '1;
            mask_reg    <= '0;
            digits      <= '1;
            frame_valid <= 1'b0;
        end else begin
            shadow_reg  <= shadow_next;
            mask_reg    <= mask_next;
            frame_valid <= full;
            if (full) begin
                digits <= shadow_reg;
            end
        end
    end

`ifdef SEG_READER_ERR_EN
    // Set has priority over a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err <= 1'b0;
        end else begin
            err <= (err && !err_clr) || pattern_err || conflict_err;
        end
    end
`else
    logic unused_err_sink;
    assign unused_err_sink = &{1'b0, err_clr, pattern_err, conflict_err};
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_reader.sv
// Randomized self-checking bench for seg_scan_reader against an activation-level reference model.
module tb_seg_scan_reader;
    localparam int DIGITS = 4;
    localparam int SETTLE = 4;
`ifdef SEG_READER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam logic [6:0] ENC [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        err_clr;
    logic [15:0] digits;
    logic        frame_valid;
    logic        err;

    seg_scan_reader #(.DIGITS(DIGITS), .SETTLE(SETTLE)) dut (
        .clk(clk), .reset_n(reset_n), .an(an), .seg(seg), .err_clr(err_clr),
        .digits(digits), .frame_valid(frame_valid), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frames_seen = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: state of the frame being assembled, kept per activation.
    logic [3:0]  m_shadow [4];
    logic [3:0]  m_mask;
    bit          m_err;
    logic [15:0] exp_q [$];
    int          exp_cyc_q [$];

    function automatic int decode_model(input logic [6:0] pat);
        for (int i = 0; i < 10; i++) if (pat == ENC[i]) return i;
        if (pat == 7'h00) return 15;
        return -1;
    endfunction

    function automatic logic [6:0] random_invalid();
        logic [6:0] pat;
        pat = 7'(($urandom_range(127, 1)));
        while (decode_model(pat) >= 0) pat = 7'(($urandom_range(127, 1)));
        return pat;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_shadow[i] = 4'hF;
        m_mask = 4'h0;
        m_err  = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
    endtask

    // Holds one anode/segment pair at the pins for dwell edges, then idles for gap edges.
    task automatic activate(input logic [3:0] act, input logic [6:0] pat, input int dwell, input int gap);
        int start, d, idx;
        start = cyc;
        an  = ~act;
        seg = ~pat;
        if ($onehot(act) && dwell >= SETTLE + 1) begin
            d = decode_model(pat);
            if (d < 0) begin
                m_err = m_err | ERR_EN;
            end else begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (act[i]) idx = i;
                m_shadow[idx] = 4'(d);
                m_mask = m_mask | act;
                if (m_mask == 4'hF) begin
                    exp_q.push_back({m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]});
                    exp_cyc_q.push_back(start + SETTLE + 4);
                    m_mask = 4'h0;
                end
            end
        end else if (act != 4'h0 && !$onehot(act) && dwell >= 1) begin
            m_err = m_err | ERR_EN;
        end
        repeat (dwell) @(negedge clk);
        an  = 4'hF;
        seg = 7'h7F;
        repeat (gap) @(negedge clk);
    endtask

    task automatic drain();
        repeat (SETTLE + 10) @(negedge clk);
    endtask

    logic fv_prev = 1'b0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (frame_valid) begin
                frames_seen++;
                $display("frame digits=%h at cycle %0d", digits, cyc);
                checks++;
                if (fv_prev) begin
                    errors++;
                    $display("FAIL fv_consecutive: frame_valid=1 on two cycles in a row at cycle %0d", cyc);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_frame: got digits=%h at cycle %0d, none expected", digits, cyc);
                end else begin
                    logic [15:0] e;
                    int c;
                    e = exp_q.pop_front();
                    c = exp_cyc_q.pop_front();
                    if (digits !== e) begin
                        errors++;
                        $display("FAIL frame_digits: got %h expected %h", digits, e);
                    end
                    checks++;
                    if (cyc != c) begin
                        errors++;
                        $display("FAIL frame_timing: got cycle %0d expected %0d", cyc, c);
                    end
                end
            end
            fv_prev = frame_valid;
        end else begin
            fv_prev = 1'b0;
        end
    end

    task automatic test_reset();
        reset_n = 1'b0; an = 4'hF; seg = 7'h7F; err_clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++; if (digits !== 16'hFFFF) begin errors++; $display("FAIL reset_digits: got %h expected ffff", digits); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b expected 0", frame_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full_scan();
        int f0;
        f0 = frames_seen;
        activate(4'b0001, 7'h4F, 8, 1);
        activate(4'b0010, 7'h5B, 8, 1);
        activate(4'b0100, 7'h06, 8, 1);
        activate(4'b1000, 7'h3F, 8, 1);
        drain();
        checks++; if (frames_seen - f0 != 1) begin errors++; $display("FAIL full_scan_count: got %0d frames expected 1", frames_seen - f0); end
        checks++; if (digits !== 16'h0123) begin errors++; $display("FAIL full_scan_digits: got %h expected 0123", digits); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL full_scan_missing: %0d frames not seen", exp_q.size()); end
    endtask

    task automatic test_short_blank();
        int f0;
        f0 = frames_seen;
        activate(4'b0001, ENC[$urandom_range(9, 0)], 8, 1);
        activate(4'b0010, ENC[$urandom_range(9, 0)], 6, 2);
        activate(4'b1000, ENC[$urandom_range(9, 0)], 7, 1);
        activate(4'b0100, ENC[5], SETTLE, 2);
        drain();
        checks++; if (frames_seen - f0 != 0) begin errors++; $display("FAIL short_dwell_frame: got %0d frames expected 0", frames_seen - f0); end
        activate(4'b0100, 7'h00, 8, 1);
        drain();
        checks++; if (frames_seen - f0 != 1) begin errors++; $display("FAIL blank_frame_count: got %0d frames expected 1", frames_seen - f0); end
        checks++; if (digits[11:8] !== 4'hF) begin errors++; $display("FAIL blank_nibble: got %h expected f", digits[11:8]); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL short_blank_missing: %0d frames not seen", exp_q.size()); end
    endtask

    task automatic test_invalid();
        int f0;
        f0 = frames_seen;
        activate(4'b0001, ENC[$urandom_range(9, 0)], 8, 1);
        activate(4'b0100, ENC[$urandom_range(9, 0)], 8, 1);
        activate(4'b1000, ENC[$urandom_range(9, 0)], 8, 1);
        activate(4'b0010, 7'h55, 8, 1);
        drain();
        checks++; if (err !== m_err) begin errors++; $display("FAIL invalid_err: got %b expected %b", err, m_err); end
        checks++; if (frames_seen - f0 != 0) begin errors++; $display("FAIL invalid_frame: got %0d frames expected 0", frames_seen - f0); end
        activate(4'b0010, 7'h7F, 8, 1);
        drain();
        checks++; if (digits[7:4] !== 4'h8) begin errors++; $display("FAIL invalid_recover: got %h expected 8", digits[7:4]); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL invalid_missing: %0d frames not seen", exp_q.size()); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_err = 1'b0;
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clr: got %b expected 0", err); end
    endtask

    task automatic test_conflict();
        activate(4'b0011, ENC[$urandom_range(9, 0)], 10, 2);
        drain();
        checks++; if (err !== m_err) begin errors++; $display("FAIL conflict_err: got %b expected %b", err, m_err); end
        for (int i = 0; i < 4; i++) activate(4'(1 << i), ENC[$urandom_range(9, 0)], $urandom_range(SETTLE + 5, SETTLE + 1), 1);
        drain();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL conflict_missing: %0d frames not seen", exp_q.size()); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic test_wrap_recapture();
        activate(4'b0001, ENC[$urandom_range(9, 0)], 8, 1);
        activate(4'b0010, 7'h06, 8, 1);
        activate(4'b0010, 7'h66, 8, 1);
        activate(4'b0100, ENC[$urandom_range(9, 0)], 8, 1);
        activate(4'b1000, ENC[$urandom_range(9, 0)], 8, 1);
        drain();
        checks++; if (digits[7:4] !== 4'h4) begin errors++; $display("FAIL recapture_nibble: got %h expected 4", digits[7:4]); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL recapture_missing: %0d frames not seen", exp_q.size()); end
    endtask

    task automatic test_random();
        int kind, dig;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(11, 0);
            dig  = $urandom_range(3, 0);
            if (kind == 0)
                activate(4'(1 << dig), ENC[$urandom_range(9, 0)], $urandom_range(SETTLE, 1), $urandom_range(3, 1));
            else if (kind == 1)
                activate(4'(1 << dig), random_invalid(), $urandom_range(SETTLE + 4, SETTLE + 1), $urandom_range(3, 1));
            else if (kind == 2)
                activate(4'b0101, ENC[$urandom_range(9, 0)], $urandom_range(6, 1), $urandom_range(3, 1));
            else if (kind == 3)
                activate(4'(1 << dig), 7'h00, $urandom_range(SETTLE + 4, SETTLE + 1), $urandom_range(3, 1));
            else
                activate(4'(1 << dig), ENC[$urandom_range(9, 0)], $urandom_range(SETTLE + 5, SETTLE + 1), $urandom_range(3, 1));
        end
        drain();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL random_missing: %0d frames not seen", exp_q.size()); end
        checks++; if (err !== m_err) begin errors++; $display("FAIL random_err: got %b expected %b", err, m_err); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_err = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        int f0;
        activate(4'b0001, ENC[$urandom_range(9, 0)], 8, 1);
        activate(4'b0010, ENC[$urandom_range(9, 0)], 8, 1);
        drain();
        an  = ~4'b0100;
        seg = ~ENC[7];
        repeat (2) @(negedge clk);
        #3 reset_n = 1'b0;
        model_reset();
        #1;
        checks++; if (digits !== 16'hFFFF) begin errors++; $display("FAIL midreset_digits: got %h expected ffff", digits); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL midreset_fv: got %b expected 0", frame_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL midreset_err: got %b expected 0", err); end
        @(negedge clk);
        an = 4'hF; seg = 7'h7F;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        f0 = frames_seen;
        activate(4'b0100, ENC[$urandom_range(9, 0)], 8, 1);
        activate(4'b1000, ENC[$urandom_range(9, 0)], 8, 1);
        activate(4'b0001, ENC[$urandom_range(9, 0)], 8, 1);
        drain();
        checks++; if (frames_seen - f0 != 0) begin errors++; $display("FAIL midreset_partial: got %0d frames expected 0", frames_seen - f0); end
        activate(4'b0010, ENC[$urandom_range(9, 0)], 8, 1);
        drain();
        checks++; if (frames_seen - f0 != 1) begin errors++; $display("FAIL midreset_frame: got %0d frames expected 1", frames_seen - f0); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL midreset_missing: %0d frames not seen", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_short_blank();
        test_invalid();
        test_conflict();
        test_wrap_recapture();
        test_random();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
